pwm_timer_mc: RTL
=================

// Module: pwm_timer_mc
// PURPOSE
//  Multi-channel, parametrised PWM timer; successor to the single-channel PWM/timer-end block.
//  NCH independent channels share one register write port.
//  Each channel runs a programmable PWM for a programmed number of periods, then pulses o_timer_end.
//  Sits on the peripheral register bus beside the other timer/counter blocks.
// PARAMETERS
//  NCH        4   number of channels (1..16)
//  CNT_W      16  period/duty counter width; also the i_wdata width
//  CYC_W      16  cycle-count width (CYC_W <= CNT_W)
//  END_PULSE  10  o_timer_end high time in clocks (>=1)
// PORTS
//  i_clk        in   1                 single clock; all logic on posedge i_clk
//  i_rst        in   1                 synchronous, active-high reset
//  i_we         in   1                 register write strobe
//  i_addr       in   $clog2(NCH)+2     [MSBs]=channel, [1:0]=reg: 0 PERIOD, 1 DUTY, 2 NCYC, 3 CTRL
//  i_wdata      in   CNT_W             write data (NCYC uses [CYC_W-1:0])
//  i_start      in   NCH               per-channel start pulse
//  i_stop       in   NCH               per-channel abort pulse
//  o_pwm        out  NCH               registered PWM outputs
//  o_timer_end  out  NCH               end-of-run pulse, END_PULSE clocks wide
//  o_busy       out  NCH               channel in RUN or DONE
// BEHAVIOUR
//  - Reset: all shadow/active regs, counters, o_pwm, o_timer_end, o_busy = 0; every FSM in IDLE.
//  - Per-channel FSM: IDLE -> RUN on i_start when PERIOD != 0 (start with PERIOD == 0 is ignored).
//    RUN -> DONE when the NCYC-th period completes.
//    DONE -> IDLE after END_PULSE clocks.
//    RUN/DONE -> IDLE on i_stop (no end pulse; o_pwm low next clock).
//  - i_start in RUN or DONE is ignored. i_stop has priority over i_start in the same cycle.
//  - Writes go to shadow regs. Active copy is loaded at start and at every period wrap (glitch-free update).
//    A write and a start on the same channel in the same cycle: the start uses the newly written value.
//  - Counter cnt counts 0..PERIOD-1 and wraps. At wrap, cyc increments; DONE when cyc+1 == NCYC.
//  - NCYC == 0: run forever until i_stop.
//  - o_pwm(t+1) = (cnt(t) < DUTY) while in RUN, else 0.
//    DUTY == 0 gives constant low; DUTY >= PERIOD gives constant high.
//  - Latency: start at cycle t -> o_busy = 1 and first PWM high bit at t+1.
//  - o_timer_end high for exactly END_PULSE clocks, starting the clock after the last period's final count.
//  - All comparisons unsigned; counters never exceed PERIOD-1; cyc wraps modulo 2^CYC_W when NCYC == 0.
//  - Reset mid-run aborts the run immediately; no end pulse is produced.
// CONFIGURATION
//  PWM_TIMER_INVERT_EN defined:
//    CTRL[0] per channel is a polarity bit; when 1, o_pwm is inverted while in RUN. Idle level stays 0.
//  PWM_TIMER_INVERT_EN undefined:
//    writes to CTRL are ignored and the polarity is always normal.
// STRUCTURE
//  - pwm_timer_pkg:
//    state enum {IDLE, RUN, DONE};
//    register offset constants REG_PERIOD, REG_DUTY, REG_NCYC, REG_CTRL;
//    CTRL bit index constant.
//  - Sub-module pwm_timer_ch: one channel (shadow regs, FSM, counters); generate-instanced NCH times.
//  - Top level: address decode and write-enable fan-out only.
// TESTING
//  1. ch0: PERIOD=4, DUTY=1, NCYC=3, start
//     -> o_pwm 1000 x3; o_timer_end high 10 clocks; o_busy falls afterwards.
//  2. ch1: DUTY=0 gives o_pwm constantly 0; DUTY=5 with PERIOD=4 gives constantly 1; both end after NCYC periods.
//  3. ch2: NCYC=0, PERIOD=8, DUTY=4; runs 100 clocks, then i_stop
//     -> o_pwm 0 next clock, no o_timer_end, o_busy 0.
//  4. ch3 in RUN with PERIOD=10: write DUTY=2 mid-period
//     -> new duty seen only after the next wrap; a start pulse in RUN is ignored.
//  5. All channels started with different PERIODs; i_rst asserted mid-run
//     -> all outputs 0 the next clock; a start with PERIOD=0 leaves the channel IDLE.
//  6. Polarity (PWM_TIMER_INVERT_EN defined): CTRL=1, PERIOD=4, DUTY=1 -> o_pwm 0111 pattern.
//     With the macro undefined, the same writes give 1000.

Source files
------------

// File: rtl/pwm_timer_pkg.sv
// Shared types and register map for the multi-channel PWM timer.
// Optional feature macro: PWM_TIMER_INVERT_EN (per-channel polarity bit in CTRL).
package pwm_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY   = 2'd1;
  localparam logic [1:0] REG_NCYC   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned CTRL_POL_BIT = 0;

endpackage

// File: rtl/pwm_timer_ch.sv
// One PWM timer channel: shadow registers, run FSM, period/cycle counters.
// Optional feature macro: PWM_TIMER_INVERT_EN (polarity bit from CTRL).
module pwm_timer_ch
  import pwm_timer_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned END_PULSE = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [1:0]       i_reg,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_pwm,
  output logic             o_timer_end,
  output logic             o_busy
);

  localparam int unsigned PW = (END_PULSE > 1) ? $clog2(END_PULSE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(END_PULSE - 1);

  state_t state, state_nx;

  logic [CNT_W-1:0] period_sh, duty_sh, period_a, duty_a;
  logic [CYC_W-1:0] ncyc_sh, ncyc_a;
  logic             pol_sh, pol_a;

  logic [CNT_W-1:0] period_ef, duty_ef;
  logic [CYC_W-1:0] ncyc_ef;
  logic             pol_ef;

  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CYC_W-1:0] cyc, cyc_nx;
  logic [PW-1:0]    pcnt, pcnt_nx;
  logic             pwm_nx;
  logic             load;

  logic             proc, wrap;
  logic [CNT_W-1:0] p_period, p_duty, p_cnt;
  logic [CYC_W-1:0] p_ncyc, p_cyc;
  logic             p_pol;

  // Effective shadow values: a write in this cycle is visible to a same-cycle start/wrap.
  always_comb begin
    period_ef = (i_we && i_reg == REG_PERIOD) ? i_wdata : period_sh;
    duty_ef   = (i_we && i_reg == REG_DUTY)   ? i_wdata : duty_sh;
    ncyc_ef   = (i_we && i_reg == REG_NCYC)   ? i_wdata[CYC_W-1:0] : ncyc_sh;
`ifdef PWM_TIMER_INVERT_EN
    pol_ef    = (i_we && i_reg == REG_CTRL)   ? i_wdata[CTRL_POL_BIT] : pol_sh;
`else
    pol_ef    = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_sh <= '0;
      duty_sh   <= '0;
      ncyc_sh   <= '0;
      pol_sh    <= 1'b0;
    end else begin
      period_sh <= period_ef;
      duty_sh   <= duty_ef;
      ncyc_sh   <= ncyc_ef;
      pol_sh    <= pol_ef;
    end
  end

  // The start cycle processes count 0 itself, so the first PWM bit appears one clock later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cyc_nx   = cyc;
    pcnt_nx  = pcnt;
    pwm_nx   = 1'b0;
    load     = 1'b0;
    proc     = 1'b0;
    wrap     = 1'b0;
    p_period = period_a;
    p_duty   = duty_a;
    p_ncyc   = ncyc_a;
    p_pol    = pol_a;
    p_cnt    = cnt;
    p_cyc    = cyc;

    case (state)
      IDLE: begin
        if (!i_stop && i_start && period_ef != '0) begin
          proc     = 1'b1;
          load     = 1'b1;
          state_nx = RUN;
          p_period = period_ef;
          p_duty   = duty_ef;
          p_ncyc   = ncyc_ef;
          p_pol    = pol_ef;
          p_cnt    = '0;
          p_cyc    = '0;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          cyc_nx   = '0;
        end else begin
          proc = 1'b1;
        end
      end
      DONE: begin
        if (i_stop || pcnt == PCNT_LAST) begin
          state_nx = IDLE;
          pcnt_nx  = '0;
        end else begin
          pcnt_nx = pcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (proc) begin
      pwm_nx = (p_cnt < p_duty) ^ p_pol;
      wrap   = ({1'b0, p_cnt} + (CNT_W+1)'(1)) >= {1'b0, p_period};
      if (wrap) begin
        cnt_nx = '0;
        load   = 1'b1;
        if (p_ncyc != '0 && (p_cyc + 1'b1) == p_ncyc) begin
          state_nx = DONE;
          pcnt_nx  = '0;
          cyc_nx   = '0;
        end else begin
          cyc_nx = p_cyc + 1'b1;
        end
      end else begin
        cnt_nx = p_cnt + 1'b1;
        cyc_nx = p_cyc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cyc      <= '0;
      pcnt     <= '0;
      o_pwm    <= 1'b0;
      period_a <= '0;
      duty_a   <= '0;
      ncyc_a   <= '0;
      pol_a    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cyc   <= cyc_nx;
      pcnt  <= pcnt_nx;
      o_pwm <= pwm_nx;
      if (load) begin
        period_a <= period_ef;
        duty_a   <= duty_ef;
        ncyc_a   <= ncyc_ef;
        pol_a    <= pol_ef;
      end
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_timer_end = (state == DONE);

endmodule

// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer top: register address decode and per-channel write fan-out.
// Optional feature macro: PWM_TIMER_INVERT_EN (handled inside each channel).
module pwm_timer_mc
  import pwm_timer_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned END_PULSE = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [$clog2(NCH)+1:0] i_addr,
  input  logic [CNT_W-1:0]       i_wdata,
  input  logic [NCH-1:0]         i_start,
  input  logic [NCH-1:0]         i_stop,
  output logic [NCH-1:0]         o_pwm,
  output logic [NCH-1:0]         o_timer_end,
  output logic [NCH-1:0]         o_busy
);

  localparam int unsigned AW   = $clog2(NCH) + 2;
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CH_W-1:0] ch_idx;
  logic [1:0]      reg_sel;

  assign reg_sel = i_addr[1:0];

  generate
    if (NCH > 1) begin : g_multi
      assign ch_idx = i_addr[AW-1:2];
    end else begin : g_single
      assign ch_idx = '0;
    end
  endgenerate

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic we_ch;
    assign we_ch = i_we && (ch_idx == CH_W'(g));

    pwm_timer_ch #(
      .CNT_W    (CNT_W),
      .CYC_W    (CYC_W),
      .END_PULSE(END_PULSE)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_we       (we_ch),
      .i_reg      (reg_sel),
      .i_wdata    (i_wdata),
      .i_start    (i_start[g]),
      .i_stop     (i_stop[g]),
      .o_pwm      (o_pwm[g]),
      .o_timer_end(o_timer_end[g]),
      .o_busy     (o_busy[g])
    );
  end

endmodule
